// File: rtl/song_pkg.sv
// -----------------------------------------------------------------------------
// song_pkg
// Shared types and constants for the song playback engine.
//   state_t     : sequencer FSM states (WAIT for a frame tick, FETCH ROM data)
//   ENV_MAX     : envelope level loaded on a drum trigger
//   SONGPOS_W   : width of the song ROM step address
//   INC_W       : width of an oscillator phase increment
//   note_to_inc : scales an 8-bit note-table entry by the octave bit
// -----------------------------------------------------------------------------
package song_pkg;

    typedef enum logic {
        WAIT  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam int          SONGPOS_W = 8;
    localparam int          INC_W     = 9;
    localparam int          NOTE_W    = 3;
    localparam int          ENV_W     = 4;
    localparam int          FRAME_W   = 4;
    localparam logic [3:0]  ENV_MAX   = 4'd15;

    // The octave bit doubles the base increment; the extra MSB keeps the
    // doubled value from overflowing.
    function automatic logic [INC_W-1:0] note_to_inc(input logic [7:0] base,
                                                     input logic       oct);
        logic [INC_W-1:0] widened;
        widened = {1'b0, base};
        return widened << oct;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// -----------------------------------------------------------------------------
// song_sequencer_if
// Song ROM bus between the sequencer and the song tables.
//   songpos, arpidx          : ROM address inputs, driven by the sequencer
//   kick_in, snare_in        : drum trigger bits for the current step
//   pulse_in                 : pulse voice mask bit for the current step
//   bass_note_in/bass_oct_in : bass table note and octave
//   pulse_note_in/pulse_oct_in : pulse table note and octave (arp-dependent)
// The ROM side is combinational from songpos/arpidx.
// -----------------------------------------------------------------------------
interface song_sequencer_if;
    import song_pkg::*;

    logic [SONGPOS_W-1:0] songpos;
    logic                 arpidx;
    logic                 kick_in;
    logic                 snare_in;
    logic                 pulse_in;
    logic [NOTE_W-1:0]    bass_note_in;
    logic                 bass_oct_in;
    logic [NOTE_W-1:0]    pulse_note_in;
    logic                 pulse_oct_in;

    modport master (
        output songpos,
        output arpidx,
        input  kick_in,
        input  snare_in,
        input  pulse_in,
        input  bass_note_in,
        input  bass_oct_in,
        input  pulse_note_in,
        input  pulse_oct_in
    );

    modport slave (
        input  songpos,
        input  arpidx,
        output kick_in,
        output snare_in,
        output pulse_in,
        output bass_note_in,
        output bass_oct_in,
        output pulse_note_in,
        output pulse_oct_in
    );

endinterface

// File: rtl/notetbl.sv
// -----------------------------------------------------------------------------
// notetbl
// Note-to-phase-increment lookup for the lowest octave.
//   note_i : 3-bit scale degree
//   inc_o  : 8-bit base phase increment (combinational)
// -----------------------------------------------------------------------------
module notetbl
    import song_pkg::*;
(
    input  logic [NOTE_W-1:0] note_i,
    output logic [7:0]        inc_o
);

    // NOTE: a constant table is pure combinational decode; it holds no state,
    // so there is nothing to reset.
    always_comb begin
        case (note_i)
            3'd0:    inc_o = 8'h47;
            3'd1:    inc_o = 8'h50;
            3'd2:    inc_o = 8'h55;
            3'd3:    inc_o = 8'h5A;
            3'd4:    inc_o = 8'h65;
            3'd5:    inc_o = 8'h71;
            3'd6:    inc_o = 8'h7F;
            default: inc_o = 8'h87;
        endcase
    end

endmodule

// File: rtl/song_env.sv
// -----------------------------------------------------------------------------
// song_env
// Drum decay envelope: load to full level, step down by one, or freeze.
//   clk, rst : clock and synchronous active-high reset
//   load_i   : jump to ENV_MAX (wins over dec_i)
//   dec_i    : decrement by one, saturating at 0
//   env_o    : registered envelope level
// -----------------------------------------------------------------------------
module song_env
    import song_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [ENV_W-1:0] env_o
);

    logic [ENV_W-1:0] env_q;
    logic [ENV_W-1:0] env_d;

    // NOTE: the next value gets a default before any branch so every path
    // assigns it and no latch is inferred.
    always_comb begin
        env_d = env_q;
        if (load_i) begin
            env_d = ENV_MAX;
        end else if (dec_i && (env_q != '0)) begin
            env_d = env_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its inputs from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end

    assign env_o = env_q;

endmodule

// File: rtl/song_sequencer.sv
// -----------------------------------------------------------------------------
// song_sequencer
// Song playback engine. Paces song steps from the frame strobe, addresses the
// song ROMs, latches note/trigger data one cycle later and drives the voice
// mixer with phase increments, gates and drum envelopes.
//   FRAMES_PER_STEP : frame ticks per song step (2..16)
//   LOOP_START      : step that follows step 255
//   clk, rst        : clock and synchronous active-high reset
//   frame_tick      : one-cycle strobe per video frame (>= 3 cycles apart)
//   run             : 1 = play, 0 = hold position and mute gates
//   rom             : song ROM bus (songpos/arpidx out, table data in)
//   bass_inc, pulse_inc   : registered oscillator phase increments
//   bass_gate, pulse_gate : voice enables
//   kick_env, snare_env   : drum envelope levels (15 struck, 0 silent)
// -----------------------------------------------------------------------------
module song_sequencer
    import song_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 6,
    parameter int LOOP_START      = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   run,
    song_sequencer_if.master       rom,
    output logic [INC_W-1:0]       bass_inc,
    output logic [INC_W-1:0]       pulse_inc,
    output logic                   bass_gate,
    output logic                   pulse_gate,
    output logic [ENV_W-1:0]       kick_env,
    output logic [ENV_W-1:0]       snare_env
);

    localparam logic [FRAME_W-1:0]   LAST_FRAME = FRAME_W'(FRAMES_PER_STEP - 1);
    localparam logic [SONGPOS_W-1:0] LOOP_POS   = SONGPOS_W'(LOOP_START);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_t               state_q,         state_d;
    logic [FRAME_W-1:0]   framecnt_q,      framecnt_d;
    logic [1:0]           arpcnt_q,        arpcnt_d;
    logic                 start_pending_q, start_pending_d;
    logic                 step_new_q,      step_new_d;
    logic [SONGPOS_W-1:0] songpos_q,       songpos_d;
    logic                 arpidx_q,        arpidx_d;
    logic [INC_W-1:0]     bass_inc_q,      bass_inc_d;
    logic [INC_W-1:0]     pulse_inc_q,     pulse_inc_d;
    logic                 bass_gate_q,     bass_gate_d;
    logic                 pulse_gate_q,    pulse_gate_d;

    // -------------------------------------------------------------------------
    // Note tables: ROM data -> base increments, captured during FETCH
    // -------------------------------------------------------------------------
    logic [7:0] bass_base;
    logic [7:0] pulse_base;

    notetbl u_bass_tbl (
        .note_i (rom.bass_note_in),
        .inc_o  (bass_base)
    );

    notetbl u_pulse_tbl (
        .note_i (rom.pulse_note_in),
        .inc_o  (pulse_base)
    );

    // -------------------------------------------------------------------------
    // Envelopes: they only move in a running FETCH cycle, so pausing freezes
    // them. Triggers load only on the first FETCH of a step (or a restart).
    // -------------------------------------------------------------------------
    logic fetch_go;
    logic kick_load;
    logic snare_load;

    assign fetch_go   = (state_q == FETCH) && run;
    assign kick_load  = fetch_go && step_new_q && rom.kick_in;
    assign snare_load = fetch_go && step_new_q && rom.snare_in;

    song_env u_kick_env (
        .clk    (clk),
        .rst    (rst),
        .load_i (kick_load),
        .dec_i  (fetch_go),
        .env_o  (kick_env)
    );

    song_env u_snare_env (
        .clk    (clk),
        .rst    (rst),
        .load_i (snare_load),
        .dec_i  (fetch_go),
        .env_o  (snare_env)
    );

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        framecnt_d      = framecnt_q;
        arpcnt_d        = arpcnt_q;
        start_pending_d = start_pending_q;
        step_new_d      = step_new_q;
        songpos_d       = songpos_q;
        arpidx_d        = arpidx_q;
        bass_inc_d      = bass_inc_q;
        pulse_inc_d     = pulse_inc_q;
        bass_gate_d     = bass_gate_q;
        pulse_gate_d    = pulse_gate_q;

        if (!run) begin
            // Pause: position and increments hold; the next tick after
            // resuming replays the current step from its start.
            state_d         = WAIT;
            start_pending_d = 1'b1;
            step_new_d      = 1'b0;
            bass_gate_d     = 1'b0;
            pulse_gate_d    = 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    if (frame_tick) begin
                        arpcnt_d = arpcnt_q + 2'd1;
                        if (arpcnt_q == 2'd3) begin
                            arpidx_d = ~arpidx_q;
                        end

                        if (start_pending_q) begin
                            // Restart re-latches the held step; step_new makes
                            // FETCH re-fire that step's triggers.
                            start_pending_d = 1'b0;
                            framecnt_d      = '0;
                            step_new_d      = 1'b1;
                        end else if (framecnt_q == LAST_FRAME) begin
                            framecnt_d = '0;
                            step_new_d = 1'b1;
                            songpos_d  = (songpos_q == '1) ? LOOP_POS
                                                           : songpos_q + 8'd1;
                        end else begin
                            framecnt_d = framecnt_q + 4'd1;
                        end

                        // ROM outputs settle on the new address during FETCH.
                        state_d = FETCH;
                    end
                end

                FETCH: begin
                    bass_inc_d   = note_to_inc(bass_base,  rom.bass_oct_in);
                    pulse_inc_d  = note_to_inc(pulse_base, rom.pulse_oct_in);
                    bass_gate_d  = 1'b1;
                    pulse_gate_d = rom.pulse_in;
                    step_new_d   = 1'b0;
                    state_d      = WAIT;
                end

                default: begin
                    state_d = WAIT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= WAIT;
            framecnt_q      <= '0;
            arpcnt_q        <= '0;
            start_pending_q <= 1'b1;
            step_new_q      <= 1'b0;
            songpos_q       <= '0;
            arpidx_q        <= 1'b0;
            bass_inc_q      <= '0;
            pulse_inc_q     <= '0;
            bass_gate_q     <= 1'b0;
            pulse_gate_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            framecnt_q      <= framecnt_d;
            arpcnt_q        <= arpcnt_d;
            start_pending_q <= start_pending_d;
            step_new_q      <= step_new_d;
            songpos_q       <= songpos_d;
            arpidx_q        <= arpidx_d;
            bass_inc_q      <= bass_inc_d;
            pulse_inc_q     <= pulse_inc_d;
            bass_gate_q     <= bass_gate_d;
            pulse_gate_q    <= pulse_gate_d;
        end
    end

    assign rom.songpos = songpos_q;
    assign rom.arpidx  = arpidx_q;
    assign bass_inc    = bass_inc_q;
    assign pulse_inc   = pulse_inc_q;
    assign bass_gate   = bass_gate_q;
    assign pulse_gate  = pulse_gate_q;

endmodule

// File: tb/tb_song_sequencer.sv
// -----------------------------------------------------------------------------
// tb_song_sequencer
// Directed bench for song_sequencer with a combinational song ROM stub.
// ROM stub contents (by songpos):
//   kick at steps 0, 3, 9; snare at steps 1, 3; pulse mask = even steps
//   bass note = songpos[2:0]^3, octave = 1 at step 0 else songpos[3]
//   pulse note = 2 when arpidx = 0, 5 when arpidx = 1, octave 0
// Note table values used for expectations: [0]=47 [1]=50 [2]=55 [3]=5A [5]=71.
// -----------------------------------------------------------------------------
module tb_song_sequencer;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic       run;
    logic [8:0] bass_inc;
    logic [8:0] pulse_inc;
    logic       bass_gate;
    logic       pulse_gate;
    logic [3:0] kick_env;
    logic [3:0] snare_env;

    song_sequencer_if rom_if ();

    song_sequencer #(
        .FRAMES_PER_STEP (6),
        .LOOP_START      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .run        (run),
        .rom        (rom_if),
        .bass_inc   (bass_inc),
        .pulse_inc  (pulse_inc),
        .bass_gate  (bass_gate),
        .pulse_gate (pulse_gate),
        .kick_env   (kick_env),
        .snare_env  (snare_env)
    );

    // Song ROM stub
    always_comb begin
        rom_if.kick_in       = (rom_if.songpos == 8'd0) || (rom_if.songpos == 8'd3) ||
                               (rom_if.songpos == 8'd9);
        rom_if.snare_in      = (rom_if.songpos == 8'd1) || (rom_if.songpos == 8'd3);
        rom_if.pulse_in      = ~rom_if.songpos[0];
        rom_if.bass_note_in  = rom_if.songpos[2:0] ^ 3'd3;
        rom_if.bass_oct_in   = (rom_if.songpos == 8'd0) ? 1'b1 : rom_if.songpos[3];
        rom_if.pulse_note_in = rom_if.arpidx ? 3'd5 : 3'd2;
        rom_if.pulse_oct_in  = 1'b0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int arp_ticks;   // ticks seen while running, drives the arpidx model
    int sp_exp;
    int kick_exp;
    int snare_exp;
    int arp_exp;
    int budget;
    logic [8:0] bass_exp [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame tick: strobe in cycle N, return at cycle N+3 (+1 time unit).
    task automatic tick();
        frame_tick = 1'b1;
        if (run) arp_ticks++;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stim
        n_cmp     = 0;
        n_err     = 0;
        arp_ticks = 0;
        bass_exp  = '{9'h0B4, 9'h055, 9'h050, 9'h047};
        rst        = 1'b1;
        run        = 1'b1;
        frame_tick = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_songpos",    rom_if.songpos, 0);
        check("rst_arpidx",     rom_if.arpidx,  0);
        check("rst_bass_inc",   bass_inc,       0);
        check("rst_pulse_inc",  pulse_inc,      0);
        check("rst_gates",      {bass_gate, pulse_gate}, 0);
        check("rst_envs",       {kick_env, snare_env},   0);

        // ---- first tick after reset, cycle 10 ----
        repeat (7) @(posedge clk);
        #1;
        frame_tick = 1'b1;
        arp_ticks++;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("t1_songpos_n1",  rom_if.songpos, 0);
        check("t1_bassinc_n1",  bass_inc,       0);
        check("t1_kick_n1",     kick_env,       0);
        @(posedge clk); #1;
        check("t1_bass_inc",    bass_inc,   9'h0B4);
        check("t1_pulse_inc",   pulse_inc,  9'h055);
        check("t1_kick_env",    kick_env,   15);
        check("t1_snare_env",   snare_env,  0);
        check("t1_bass_gate",   bass_gate,  1);
        check("t1_pulse_gate",  pulse_gate, 1);
        @(posedge clk); #1;

        // ---- pacing, envelopes and arpeggio over ticks 2..20 ----
        for (int k = 2; k <= 20; k++) begin
            tick();
            sp_exp    = (k - 1) / 6;
            kick_exp  = (k <= 16) ? 16 - k : ((k < 19) ? 0 : 34 - k);
            snare_exp = (k < 7) ? 0 : ((k < 19) ? 22 - k : 34 - k);
            arp_exp   = (arp_ticks / 4) % 2;
            check("pace_songpos", rom_if.songpos, sp_exp);
            check("arp_idx",      rom_if.arpidx,  arp_exp);
            check("arp_pulse_inc", pulse_inc, (arp_exp != 0) ? 9'h071 : 9'h055);
            check("step_bass_inc", bass_inc,  bass_exp[sp_exp]);
            check("kick_env",     kick_env,   kick_exp);
            check("snare_env",    snare_env,  snare_exp);
            check("pulse_gate",   pulse_gate, (sp_exp % 2) == 0);
        end

        // ---- advance to songpos 9, framecnt 3 (tick 58) ----
        repeat (38) tick();
        check("pre_pause_songpos", rom_if.songpos, 9);
        check("pre_pause_kick",    kick_env,       12);
        check("pre_pause_snare",   snare_env,      0);
        check("pre_pause_bassinc", bass_inc,       9'h0AA);
        check("pre_pause_arpidx",  rom_if.arpidx,  (arp_ticks / 4) % 2);

        // ---- pause ----
        run = 1'b0;
        @(posedge clk); #1;
        check("pause_bass_gate",  bass_gate,      0);
        check("pause_pulse_gate", pulse_gate,     0);
        check("pause_songpos",    rom_if.songpos, 9);
        check("pause_kick",       kick_env,       12);
        tick();
        check("pause_tick_songpos", rom_if.songpos, 9);
        check("pause_tick_kick",    kick_env,       12);
        check("pause_tick_bassinc", bass_inc,       9'h0AA);
        check("pause_tick_arpidx",  rom_if.arpidx,  (arp_ticks / 4) % 2);
        check("pause_tick_gate",    bass_gate,      0);

        // ---- resume: same step replays, then a full step to advance ----
        run = 1'b1;
        @(posedge clk); #1;
        tick();
        check("resume_songpos",   rom_if.songpos, 9);
        check("resume_kick",      kick_env,       15);
        check("resume_bass_gate", bass_gate,      1);
        check("resume_arpidx",    rom_if.arpidx,  (arp_ticks / 4) % 2);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("resume_hold_songpos", rom_if.songpos, 9);
        end
        tick();
        check("resume_advance_songpos", rom_if.songpos, 10);

        // ---- wrap 255 -> LOOP_START ----
        budget = 2000;
        while ((rom_if.songpos !== 8'd255) && (budget > 0)) begin
            tick();
            budget--;
        end
        check("wrap_reach_255", rom_if.songpos, 255);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("wrap_hold_255", rom_if.songpos, 255);
        end
        tick();
        check("wrap_songpos", rom_if.songpos, 32);
        check("wrap_arpidx",  rom_if.arpidx,  (arp_ticks / 4) % 2);
        tick();
        check("wrap_next_songpos", rom_if.songpos, 32);
        check("wrap_next_arpidx",  rom_if.arpidx,  (arp_ticks / 4) % 2);

        // ---- reset mid-step ----
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        arp_ticks = 0;
        check("midrst_songpos", rom_if.songpos, 0);
        check("midrst_arpidx",  rom_if.arpidx,  0);
        check("midrst_incs",    {bass_inc, pulse_inc},   0);
        check("midrst_gates",   {bass_gate, pulse_gate}, 0);
        check("midrst_envs",    {kick_env, snare_env},   0);
        tick();
        check("postrst_songpos",  rom_if.songpos, 0);
        check("postrst_kick",     kick_env,       15);
        check("postrst_bass_inc", bass_inc,       9'h0B4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Playback engine that reads the song tables: paces song steps from the video frame strobe, drives `songpos` and `arpidx` into the song ROMs, and latches their note and trigger outputs. It turns note/octave pairs into oscillator phase increments through two note-table lookups, and runs the kick and snare decay envelopes. It sits between the frame timing and the audio voice mixer.

## Interface
- `FRAMES_PER_STEP`, default 6: frame ticks per song step; legal range 2..16.
- `LOOP_START`, default 0: value `songpos` takes when it advances past 255.
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `frame_tick`  in  1: one-cycle strobe per video frame; at least 3 cycles apart by contract.
- `run`  in  1: 1 = play, 0 = hold position and mute gates.
- `songpos`  out  8: current step; drives the song ROM address inputs.
- `arpidx`  out  1: arpeggio selector to the pulse table.
- `kick_in`, `snare_in`, `pulse_in`  in  1 each: trigger and mask bits from the ROMs.
- `bass_note_in`  in  3, `bass_oct_in`  in  1: bass table outputs.
- `pulse_note_in`  in  3, `pulse_oct_in`  in  1: pulse table outputs.
- `bass_inc`, `pulse_inc`  out  9: registered phase increments.
- `bass_gate`, `pulse_gate`  out  1: voice enables.
- `kick_env`, `snare_env`  out  4: envelope levels; 15 = struck, 0 = silent.

## Operation
- **Reset:**
  - All outputs are 0.
  - `framecnt` = 0, `arpcnt` = 0.
  - `start_pending` = 1.
  - State is WAIT.
- **WAIT, `frame_tick`=1, `run`=1:**
  - If `start_pending`: clear `start_pending` and set `framecnt` to 0. `songpos` does not change.
  - Else if `framecnt` = `FRAMES_PER_STEP`-1: set `framecnt` to 0 and set `step_new` to 1. `songpos` increments; 255 wraps to `LOOP_START`.
  - Else: `framecnt` increments.
  - `arpcnt` increments (2-bit). `arpidx` toggles when `arpcnt` wraps from 3 to 0.
  - Go to FETCH. ROM outputs are combinational from `songpos` and `arpidx`, so this cycle lets them settle.
- **FETCH (one cycle):**
  - `bass_inc` = `{1'b0, notetbl[bass_note_in]} << bass_oct_in`. Same rule for `pulse_inc` from the pulse inputs.
  - `pulse_gate` = `pulse_in`; `bass_gate` = 1.
  - On a step boundary or restart:
    - `kick_in`=1 loads `kick_env` to 15; `snare_in`=1 loads `snare_env` to 15.
    - A load wins over a decrement in the same cycle.
  - Otherwise each nonzero envelope decrements by 1. Envelopes saturate at 0.
  - Clear `step_new`, then return to WAIT.
- Increments are re-latched every frame, so an `arpidx` change takes effect within the step.
- **`run`=0, any state:**
  - Enter WAIT and set `start_pending`=1.
  - `bass_gate` and `pulse_gate` are 0 on the next edge.
  - `songpos`, `arpidx` and the increments hold.
  - Envelopes freeze.
- When `run` returns to 1, the first tick re-latches the same `songpos` and re-fires its triggers.
- A `frame_tick` that arrives while in FETCH is ignored.
- `rst` has priority over everything, mid-step included.

## Timing
- Tick in cycle N → `songpos`, `arpidx` and `framecnt` change at the edge ending cycle N.
- Increments, gates and envelopes change at the edge ending cycle N+1. Outputs are valid from cycle N+2.
- Steady-state step period is exactly `FRAMES_PER_STEP` frame ticks.
- All outputs are registered. The only combinational paths are ROM inputs → FETCH capture registers.
- Envelope decay is 15 frames from 15 to 0.

## Structure
- Shared package `song_pkg` holds:
  - the `state_t` enum {WAIT, FETCH};
  - `ENV_MAX`=4'd15;
  - the `SONGPOS_W`=8 and `INC_W`=9 constants.
- Instantiate the existing `notetbl` twice (bass, pulse).
- One natural sub-module, `song_env`: 4-bit load/decrement/freeze envelope, instantiated for kick and snare.

## Test plan
- **First tick after reset:** `rst` for 2 cycles, `run`=1, tick at cycle 10, ROM stub bass note 3/oct 1 with `notetbl[3]`=8'h5A, kick=1 → `songpos`=0 at cycle 11, `bass_inc`=9'h0B4 and `kick_env`=15 at cycle 12.
- **Step pacing:** 13 ticks from reset → `songpos` goes 0→1 on tick 7 and 1→2 on tick 13, never otherwise.
- **Wrap:** `LOOP_START`=32, drive to `songpos`=255, complete one step → `songpos`=32, `arpidx` unaffected.
- **Envelope:** kick on step 0 only → `kick_env` 15,14,…,0 across 16 ticks, then holds 0. Kick again when `kick_env`=3 → 15, not 2.
- **Arpeggio:** pulse1 note 2, pulse2 note 5 → `arpidx` toggles every 4 ticks, and `pulse_inc` alternates between `notetbl[2]` and `notetbl[5]` values one cycle later.
- **Pause and resume:** drop `run` at `framecnt`=3 on `songpos`=9 → gates 0 next cycle, `songpos` holds 9, envelopes frozen. Raise `run`, tick → `songpos` stays 9, triggers re-fire, next advance after 6 ticks.
